dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width driven to the RAM; byte-address bits [ADDR_W+1:2] used.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cpu_req  input  1  pipeline MEM-stage access request, held high until cpu_ack.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address; bits [1:0] and above [ADDR_W+1] ignored.
REQ-008 cpu_wdata  input  DATA_W  write data.
REQ-009 cpu_rdata  output  DATA_W  read data, valid when cpu_ack=1 on a read.
REQ-010 cpu_ack  output  1  one-cycle completion pulse.
REQ-011 cpu_stall  output  1  pipeline freeze request.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same widths and meaning as the cpu_* ports, for the debug/loader port.
REQ-013 ram_en  output  1  RAM access strobe.
REQ-014 ram_we  output  1  RAM write enable, only meaningful with ram_en.
REQ-015 ram_addr  output  ADDR_W  RAM word address.
REQ-016 ram_wdata  output  DATA_W  RAM write data.
REQ-017 ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_en=1 with ram_we=0.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; one access per IDLE->ACCESS->RESP->IDLE sequence (3 cycles).
REQ-019 IDLE: with no request, stay IDLE; ram_en=0.
REQ-020 IDLE with exactly one request pending: grant that requester; latch its we, addr[ADDR_W+1:2] and wdata into the ram_* output registers; go to ACCESS.
REQ-021 IDLE with both requests pending: grant the requester not in last_grant (round-robin); last_grant resets to dbg, so the cpu wins the first conflict after reset.
REQ-022 last_grant updated on every grant, including uncontested grants.
REQ-023 ACCESS: ram_en=1 for exactly this one cycle, with ram_we/ram_addr/ram_wdata from the latched grant; unconditionally go to RESP.
REQ-024 RESP: ack pulse to the granted port only; on a read, capture ram_rdata into that port's rdata register in this same cycle; go to IDLE.
REQ-025 rdata registers hold their value until the next read completion on the same port; write completions leave rdata unchanged.
REQ-026 The requester drops or changes req in the cycle after ack; IDLE re-samples requests, so no request is served twice.
REQ-027 Once granted, an access always completes and acks even if req drops mid-access; the arbiter takes no abort action.
REQ-028 cpu_stall = cpu_req AND NOT cpu_ack (combinational); dbg traffic stalls the cpu only while cpu_req=1.
REQ-029 Worst-case cpu wait under continuous contention: one dbg access (3 cycles) plus its own access.
REQ-030 Both ack outputs are never high in the same cycle, and ram_en is never high for two consecutive cycles.

Reset
REQ-031 rst=1 forces, asynchronously: state IDLE, last_grant=dbg, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_ack=0, dbg_ack=0, cpu_rdata=0, dbg_rdata=0.
REQ-032 rst asserted during ACCESS or RESP discards the in-flight access with no ack; a write in ACCESS may or may not reach the RAM.
REQ-033 First grant is possible in the first IDLE cycle after rst deasserts.

Verification
REQ-034 Reset: assert rst while in ACCESS -> in the same cycle ram_en=0, acks=0 and all rdata=0; after release, state is IDLE.
REQ-035 CPU write then read: cpu write addr 0x10, data 21, then read 0x10 -> ram_addr=4 on both accesses; the read's cpu_ack comes 3 cycles after the request and cpu_rdata=21.
REQ-036 First conflict: cpu and dbg both request in the first cycle after reset -> cpu acks first, dbg acks 3 cycles later.
REQ-037 Continuous contention: both requests held high for 12 cycles -> grants alternate cpu, dbg, cpu, dbg; 4 acks total; ram_en is never high on consecutive cycles.
REQ-038 Dbg only: dbg write 0x8f0ff00b to addr 0x10 with cpu_req=0 -> cpu_stall stays 0; a later cpu read of 0x10 returns 0x8f0ff00b.
REQ-039 Early drop: cpu_req deasserted during ACCESS -> cpu_ack still pulses in RESP and the FSM returns to IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (cpu / debug) round-robin arbiter in front of a single-port data RAM.
// Each granted access walks IDLE -> ACCESS -> RESP and acks only the granted port.
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {GNT_CPU, GNT_DBG} grant_t;

    state_t            state, state_nx;
    grant_t            last_grant, grant, pick;
    logic              take;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              addr_unused;

    assign addr_unused = ^{cpu_addr[1:0], cpu_addr[31:ADDR_W+2],
                           dbg_addr[1:0], dbg_addr[31:ADDR_W+2]};

    always_comb begin
        state_nx = state;
        pick     = last_grant;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req && dbg_req) begin
                    take = 1'b1;
                    pick = (last_grant == GNT_DBG) ? GNT_CPU : GNT_DBG;
                end else if (cpu_req) begin
                    take = 1'b1;
                    pick = GNT_CPU;
                end else if (dbg_req) begin
                    take = 1'b1;
                    pick = GNT_DBG;
                end
                if (take) state_nx = ACCESS;
            end
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GNT_DBG;
            grant       <= GNT_DBG;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state   <= state_nx;
            ram_en  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            if (take) begin
                grant      <= pick;
                last_grant <= pick;
                ram_en     <= 1'b1;
                if (pick == GNT_CPU) begin
                    ram_we    <= cpu_we;
                    ram_addr  <= cpu_addr[ADDR_W+1:2];
                    ram_wdata <= cpu_wdata;
                end else begin
                    ram_we    <= dbg_we;
                    ram_addr  <= dbg_addr[ADDR_W+1:2];
                    ram_wdata <= dbg_wdata;
                end
            end
            if (state == ACCESS) begin
                cpu_ack <= (grant == GNT_CPU);
                dbg_ack <= (grant == GNT_DBG);
            end
            // ram_we still holds the granted access's direction during RESP
            if (state == RESP && !ram_we) begin
                if (grant == GNT_CPU) cpu_rdata_q <= ram_rdata;
                else                  dbg_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM data is only present during RESP, so the ack cycle forwards it
    // directly; the registered copy covers every later cycle.
    assign cpu_rdata = (cpu_ack && !ram_we) ? ram_rdata : cpu_rdata_q;
    assign dbg_rdata = (dbg_ack && !ram_we) ? ram_rdata : dbg_rdata_q;
    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected acks into a
// scoreboard queue, a negedge monitor pops and compares on every ack.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack, cpu_stall;
    logic        dbg_req = 0, dbg_we = 0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack;
    logic        ram_en, ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_dbg;
        bit          we;
        logic [13:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [int unsigned];
    bit          prev_en = 1'b0;
    int          ram_en_cnt = 0;
    bit          stall_watch = 1'b0;
    logic        seen_we;
    logic [13:0] seen_addr;
    logic [31:0] seen_wdata;

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // synchronous-read RAM model
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] = ram_wdata;
            else        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_dbg, input bit we, input logic [13:0] addr, input logic [31:0] data);
        exp_t e;
        e.is_dbg = is_dbg; e.we = we; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ram_en) begin
            chk("ram_en_gap", {31'b0, prev_en}, 32'd0);
            ram_en_cnt++;
            seen_we    = ram_we;
            seen_addr  = ram_addr;
            seen_wdata = ram_wdata;
        end
        prev_en = ram_en;
        if (cpu_ack || dbg_ack) begin
            chk("ack_exclusive", {31'b0, cpu_ack && dbg_ack}, 32'd0);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got cpu_ack=%0b dbg_ack=%0b expected none", cpu_ack, dbg_ack);
            end else begin
                e = sb.pop_front();
                chk("ack_port", {31'b0, dbg_ack}, {31'b0, e.is_dbg});
                chk("ram_we", {31'b0, seen_we}, {31'b0, e.we});
                chk("ram_addr", {18'b0, seen_addr}, {18'b0, e.addr});
                if (e.we) chk("ram_wdata", seen_wdata, e.data);
                else      chk("rdata", e.is_dbg ? dbg_rdata : cpu_rdata, e.data);
            end
        end
        if (stall_watch) chk("cpu_stall_dbg_only", {31'b0, cpu_stall}, 32'd0);
    end

    // raise a request, wait (bounded) for its ack, report cycles-to-ack
    task automatic drive(input bit is_dbg, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit drop_early, output int lat);
        bit got = 0;
        lat = 0;
        if (is_dbg) begin dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; end
        else        begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (drop_early && i == 2) begin
                if (is_dbg) dbg_req = 0; else cpu_req = 0;
            end
            if ((is_dbg && dbg_ack) || (!is_dbg && cpu_ack)) begin
                got = 1;
                lat = i;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles (port dbg=%0b)", is_dbg);
        end
        @(posedge clk); #1;
        if (is_dbg) dbg_req = 0; else cpu_req = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat_c, lat_d, base;
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_c, lat_d, base;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("rst_ram_addr", {18'b0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_acks", {30'b0, cpu_ack, dbg_ack}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);

        // first conflict right after reset: cpu first, dbg 3 cycles later
        push(0, 1, 14'h10, 32'h11);
        push(1, 1, 14'h11, 32'h22);
        rst = 0;
        fork
            drive(0, 1, 32'h40, 32'h11, 0, lat_c);
            drive(1, 1, 32'h44, 32'h22, 0, lat_d);
        join
        chk("conflict_cpu_lat", lat_c, 3);
        chk("conflict_dbg_lat", lat_d, 6);
        idle(2);

        // continuous contention for 12 cycles: cpu, dbg, cpu, dbg
        base = ram_en_cnt;
        push(0, 1, 14'h8, 32'hA1); push(1, 1, 14'h9, 32'hB2);
        push(0, 1, 14'h8, 32'hA1); push(1, 1, 14'h9, 32'hB2);
        cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hA1;
        dbg_we = 1; dbg_addr = 32'h24; dbg_wdata = 32'hB2;
        cpu_req = 1; dbg_req = 1;
        idle(12);
        cpu_req = 0; dbg_req = 0;
        idle(3);
        chk("contention_accesses", ram_en_cnt - base, 4);

        // cpu write 21 to 0x10, then read back
        push(0, 1, 14'h4, 32'd21);
        drive(0, 1, 32'h10, 32'd21, 0, lat_c);
        idle(2);
        push(0, 0, 14'h4, 32'd21);
        drive(0, 0, 32'h10, 32'h0, 0, lat_c);
        chk("read_lat", lat_c, 3);
        idle(2);

        // debug-only write must never stall the cpu; cpu reads it back
        push(1, 1, 14'h4, 32'h8f0ff00b);
        stall_watch = 1;
        drive(1, 1, 32'h10, 32'h8f0ff00b, 0, lat_d);
        stall_watch = 0;
        idle(2);
        push(0, 0, 14'h4, 32'h8f0ff00b);
        drive(0, 0, 32'h10, 32'h0, 0, lat_c);
        idle(2);
        push(1, 0, 14'h10, 32'h11);
        drive(1, 0, 32'h40, 32'h0, 0, lat_d);
        idle(2);

        // early drop of cpu_req during ACCESS: ack still comes, no re-serve
        base = ram_en_cnt;
        push(0, 0, 14'h11, 32'h22);
        drive(0, 0, 32'h44, 32'h0, 1, lat_c);
        chk("early_drop_lat", lat_c, 3);
        idle(4);
        chk("early_drop_accesses", ram_en_cnt - base, 1);

        // reset asserted while in ACCESS
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        @(posedge clk); #2;
        rst = 1; #1;
        chk("midrst_ram_en", {31'b0, ram_en}, 32'd0);
        chk("midrst_acks", {30'b0, cpu_ack, dbg_ack}, 32'd0);
        chk("midrst_cpu_rdata", cpu_rdata, 32'd0);
        chk("midrst_dbg_rdata", dbg_rdata, 32'd0);
        cpu_req = 0;
        idle(2);
        rst = 0;
        idle(3);
        push(0, 0, 14'h4, 32'h8f0ff00b);
        drive(0, 0, 32'h10, 32'h0, 0, lat_c);
        chk("post_rst_lat", lat_c, 3);
        idle(3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
